// File: rtl/mb_updown_counter_n.sv
// N-digit presettable up/down counter, counting as one binary word or as packed BCD decades.
// CarryOut is an active-low terminal-count output and is meant to drive CE of the next stage.
module mb_updown_counter_n #(
  parameter int N_DIGITS = 4
) (
  input  logic                    CLK,
  input  logic                    RST_bar,
  input  logic [4*N_DIGITS-1:0]   J,
  input  logic                    PE,
  input  logic                    CE,
  input  logic                    UpDown_bar,
  input  logic                    BinDec,
  output logic [4*N_DIGITS-1:0]   Q,
  output logic                    CarryOut,
  output logic                    Wrapped
);

  localparam int W = 4 * N_DIGITS;
  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] bin_next;
  logic [W-1:0] dec_next;
  logic [W-1:0] count_next;
  logic [3:0]   digit;
  logic         ripple;
  logic         all_nines;
  logic         term_up;
  logic         term_down;
  logic         terminal;
  logic         count_en;

  assign count_en = ~CE;

  assign bin_next = UpDown_bar ? (Q + ONE) : (Q - ONE);

  // Decade chain: only digit 0 sees the initial step; higher digits move on carry/borrow.
  // Digits holding 10..15 count up like 9 (wrap to 0 with carry) and count down normally.
  always_comb begin
    dec_next = Q;
    digit    = 4'd0;
    ripple   = 1'b1;
    for (int i = 0; i < N_DIGITS; i++) begin
      digit = Q[4*i +: 4];
      if (ripple) begin
        if (UpDown_bar) begin
          if (digit >= 4'd9) begin
            dec_next[4*i +: 4] = 4'd0;
          end else begin
            dec_next[4*i +: 4] = digit + 4'd1;
            ripple = 1'b0;
          end
        end else begin
          if (digit == 4'd0) begin
            dec_next[4*i +: 4] = 4'd9;
          end else begin
            dec_next[4*i +: 4] = digit - 4'd1;
            ripple = 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    all_nines = 1'b1;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (Q[4*i +: 4] < 4'd9) all_nines = 1'b0;
    end
  end

  assign term_up    = BinDec ? (&Q) : all_nines;
  assign term_down  = (Q == '0);
  assign terminal   = UpDown_bar ? term_up : term_down;
  assign count_next = BinDec ? bin_next : dec_next;

  // PE deliberately does not gate CarryOut so a cascade keeps its terminal detect during preset.
  assign CarryOut = ~(count_en & terminal);

  always_ff @(posedge CLK or negedge RST_bar) begin
    if (!RST_bar) begin
      Q       <= '0;
      Wrapped <= 1'b0;
    end else if (PE) begin
      Q       <= J;
      Wrapped <= 1'b0;
    end else if (count_en) begin
      Q       <= count_next;
      Wrapped <= terminal;
    end else begin
      Wrapped <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mb_updown_counter_n.sv
// Directed bench for mb_updown_counter_n: a 2-digit instance plus a two-stage 1-digit cascade.
module tb_mb_updown_counter_n;

  logic       clk;
  logic       rst_n;
  logic [7:0] j;
  logic       pe, ce, ud, bd;
  logic [7:0] q;
  logic       co, wr;

  logic [3:0] jc0, jc1;
  logic       pc, ce0, bdc, udc;
  logic [3:0] q0, q1;
  logic       co0, co1, wr0, wr1;

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mb_updown_counter_n #(.N_DIGITS(2)) dut (
    .CLK(clk), .RST_bar(rst_n), .J(j), .PE(pe), .CE(ce), .UpDown_bar(ud),
    .BinDec(bd), .Q(q), .CarryOut(co), .Wrapped(wr)
  );

  mb_updown_counter_n #(.N_DIGITS(1)) stage0 (
    .CLK(clk), .RST_bar(rst_n), .J(jc0), .PE(pc), .CE(ce0), .UpDown_bar(udc),
    .BinDec(bdc), .Q(q0), .CarryOut(co0), .Wrapped(wr0)
  );

  mb_updown_counter_n #(.N_DIGITS(1)) stage1 (
    .CLK(clk), .RST_bar(rst_n), .J(jc1), .PE(pc), .CE(co0), .UpDown_bar(udc),
    .BinDec(bdc), .Q(q1), .CarryOut(co1), .Wrapped(wr1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] val);
    j  = val;
    pe = 1'b1;
    step();
    pe = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    j = 8'h00; pe = 1'b0; ce = 1'b1; ud = 1'b1; bd = 1'b1;
    jc0 = 4'h0; jc1 = 4'h0; pc = 1'b0; ce0 = 1'b1; bdc = 1'b0; udc = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL reset_q act=%h exp=%h", q, 8'h00); end
    checks++; if (wr !== 1'b0) begin errors++; $display("FAIL reset_wrapped act=%b exp=0", wr); end
    checks++; if (co !== 1'b1) begin errors++; $display("FAIL reset_co_ce_off act=%b exp=1", co); end
    ce = 1'b0; ud = 1'b0; #1;
    checks++; if (co !== 1'b0) begin errors++; $display("FAIL reset_co_down_at_zero act=%b exp=0", co); end
    ud = 1'b1; #1;
    checks++; if (co !== 1'b1) begin errors++; $display("FAIL reset_co_up_at_zero act=%b exp=1", co); end
    ce = 1'b1;
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset_mid_count();
    bd = 1'b1; ud = 1'b1; ce = 1'b0;
    load(8'h35);
    step(); step();
    checks++; if (q !== 8'h37) begin errors++; $display("FAIL midreset_pre act=%h exp=%h", q, 8'h37); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL midreset_q act=%h exp=%h", q, 8'h00); end
    checks++; if (wr !== 1'b0) begin errors++; $display("FAIL midreset_wr act=%b exp=0", wr); end
    #1 rst_n = 1'b1;
    step();
    checks++; if (q !== 8'h01) begin errors++; $display("FAIL midreset_resume act=%h exp=%h", q, 8'h01); end
    ce = 1'b1;
  endtask

  task automatic test_binary_wrap();
    bd = 1'b1; ud = 1'b1; ce = 1'b1;
    load(8'hFF);
    ce = 1'b0; #1;
    checks++; if (co !== 1'b0) begin errors++; $display("FAIL binwrap_co act=%b exp=0", co); end
    step();
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL binwrap_q act=%h exp=%h", q, 8'h00); end
    checks++; if (wr !== 1'b1) begin errors++; $display("FAIL binwrap_wr act=%b exp=1", wr); end
    step();
    checks++; if (q !== 8'h01) begin errors++; $display("FAIL binwrap_q2 act=%h exp=%h", q, 8'h01); end
    checks++; if (wr !== 1'b0) begin errors++; $display("FAIL binwrap_wr_one_cycle act=%b exp=0", wr); end
    ud = 1'b0;
    step();
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL bindown_q act=%h exp=%h", q, 8'h00); end
    checks++; if (co !== 1'b0) begin errors++; $display("FAIL bindown_co act=%b exp=0", co); end
    step();
    checks++; if (q !== 8'hFF) begin errors++; $display("FAIL bindown_wrap act=%h exp=%h", q, 8'hFF); end
    checks++; if (wr !== 1'b1) begin errors++; $display("FAIL bindown_wr act=%b exp=1", wr); end
    ce = 1'b1;
    step();
    checks++; if (q !== 8'hFF) begin errors++; $display("FAIL hold_q act=%h exp=%h", q, 8'hFF); end
    checks++; if (wr !== 1'b0) begin errors++; $display("FAIL hold_wr act=%b exp=0", wr); end
    checks++; if (co !== 1'b1) begin errors++; $display("FAIL hold_co act=%b exp=1", co); end
  endtask

  task automatic test_decade();
    bd = 1'b0; ce = 1'b0; ud = 1'b1;
    load(8'h19);
    step();
    checks++; if (q !== 8'h20) begin errors++; $display("FAIL dec_19_up act=%h exp=%h", q, 8'h20); end
    checks++; if (wr !== 1'b0) begin errors++; $display("FAIL dec_19_wr act=%b exp=0", wr); end
    load(8'h99);
    checks++; if (co !== 1'b0) begin errors++; $display("FAIL dec_99_co act=%b exp=0", co); end
    step();
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL dec_99_up act=%h exp=%h", q, 8'h00); end
    checks++; if (wr !== 1'b1) begin errors++; $display("FAIL dec_99_wr act=%b exp=1", wr); end
    ud = 1'b0;
    load(8'h10);
    step();
    checks++; if (q !== 8'h09) begin errors++; $display("FAIL dec_10_down act=%h exp=%h", q, 8'h09); end
    load(8'h00);
    checks++; if (co !== 1'b0) begin errors++; $display("FAIL dec_00_co act=%b exp=0", co); end
    step();
    checks++; if (q !== 8'h99) begin errors++; $display("FAIL dec_00_down act=%h exp=%h", q, 8'h99); end
    checks++; if (wr !== 1'b1) begin errors++; $display("FAIL dec_00_wr act=%b exp=1", wr); end
    step();
    checks++; if (q !== 8'h98) begin errors++; $display("FAIL dec_99_down act=%h exp=%h", q, 8'h98); end
    checks++; if (wr !== 1'b0) begin errors++; $display("FAIL dec_wr_one_cycle act=%b exp=0", wr); end
    ce = 1'b1;
  endtask

  task automatic test_illegal_bcd();
    bd = 1'b0; ce = 1'b0; ud = 1'b1;
    load(8'h0C);
    checks++; if (q !== 8'h0C) begin errors++; $display("FAIL illegal_load act=%h exp=%h", q, 8'h0C); end
    step();
    checks++; if (q !== 8'h10) begin errors++; $display("FAIL illegal_up act=%h exp=%h", q, 8'h10); end
    ud = 1'b0;
    load(8'h0C);
    step();
    checks++; if (q !== 8'h0B) begin errors++; $display("FAIL illegal_down act=%h exp=%h", q, 8'h0B); end
    ud = 1'b1;
    load(8'hCA);
    checks++; if (co !== 1'b0) begin errors++; $display("FAIL illegal_term_co act=%b exp=0", co); end
    step();
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL illegal_term_up act=%h exp=%h", q, 8'h00); end
    checks++; if (wr !== 1'b1) begin errors++; $display("FAIL illegal_term_wr act=%b exp=1", wr); end
    ce = 1'b1;
  endtask

  task automatic test_preset_priority();
    bd = 1'b1; ud = 1'b1; ce = 1'b1;
    load(8'hFF);
    j = 8'h5A; pe = 1'b1; ce = 1'b0; #1;
    checks++; if (co !== 1'b0) begin errors++; $display("FAIL pe_co_not_gated act=%b exp=0", co); end
    step();
    checks++; if (q !== 8'h5A) begin errors++; $display("FAIL pe_priority_q act=%h exp=%h", q, 8'h5A); end
    checks++; if (wr !== 1'b0) begin errors++; $display("FAIL pe_priority_wr act=%b exp=0", wr); end
    pe = 1'b0; ce = 1'b1;
  endtask

  task automatic test_cascade();
    int cnt;
    int pulses;
    bdc = 1'b0; udc = 1'b1; ce0 = 1'b0;
    jc0 = 4'h9; jc1 = 4'h9; pc = 1'b1;
    step();
    pc = 1'b0; #1;
    checks++; if (co1 !== 1'b0) begin errors++; $display("FAIL casc_co1_at_99 act=%b exp=0", co1); end
    step();
    checks++; if ({q1, q0} !== 8'h00) begin errors++; $display("FAIL casc_99_up act=%h exp=%h", {q1, q0}, 8'h00); end
    checks++; if (wr1 !== 1'b1) begin errors++; $display("FAIL casc_99_wr1 act=%b exp=1", wr1); end
    for (int s = 1; s <= 150; s++) begin
      step();
      cnt = s % 100;
      if (q0 !== 4'(cnt % 10) || q1 !== 4'(cnt / 10)) begin
        errors++; $display("FAIL casc_count step=%0d act=%h%h exp=%0d", s, q1, q0, cnt);
      end
      checks++;
      if (co1 !== ((cnt == 99) ? 1'b0 : 1'b1)) begin
        errors++; $display("FAIL casc_co1 step=%0d act=%b exp=%b", s, co1, (cnt == 99) ? 1'b0 : 1'b1);
      end
      checks++;
    end
    checks++; if ({q1, q0} !== 8'h50) begin errors++; $display("FAIL casc_150 act=%h exp=%h", {q1, q0}, 8'h50); end
    bdc = 1'b1;
    jc0 = 4'h0; pc = 1'b1;
    step();
    pc = 1'b0;
    pulses = 0;
    for (int s = 0; s < 32; s++) begin
      step();
      if (wr0 === 1'b1) pulses++;
    end
    checks++; if (pulses != 2) begin errors++; $display("FAIL bin1_wrap_pulses act=%0d exp=2", pulses); end
    checks++; if (q0 !== 4'h0) begin errors++; $display("FAIL bin1_q_after_32 act=%h exp=0", q0); end
    ce0 = 1'b1;
  endtask

  initial begin
    test_reset();
    test_reset_mid_count();
    test_binary_wrap();
    test_decade();
    test_illegal_bcd();
    test_preset_priority();
    test_cascade();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
